// File: rtl/dm_pkg.sv
// dm_pkg: shared state encoding, default geometry and modulo-length window arithmetic
package dm_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WRITE, WAIT} state_t;
   localparam int COLS_DEF = 16;
   localparam int ROWS_DEF = 16;
   function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b, input int unsigned m);
      return (a + b >= m) ? a + b - m : a + b;
   endfunction
   function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b, input int unsigned m);
      return (a >= b) ? a - b : a + m - b;
   endfunction
endpackage

// File: rtl/dm_tick_div.sv
// dm_tick_div: free-running scroll-step divider, held at zero while not running
module dm_tick_div #(
   parameter int TICK_DIV = 50000,
   localparam int CW = $clog2(TICK_DIV)
)(
   input  logic CLK,
   input  logic RESET,
   input  logic run,
   output logic tick
);
   logic [CW-1:0] count;
   assign tick = run && count == CW'(TICK_DIV - 1);
   always_ff @(posedge CLK)
      if (!RESET || !run) count <= '0;
      else count <= (count == CW'(TICK_DIV - 1)) ? '0 : count + 1'b1;
endmodule

// File: rtl/dm_scroll_feeder.sv
// dm_scroll_feeder: marquee window writer for the 16x16 dot-matrix driver
// DM_FEEDER_DIR_EN adds a DIR input selecting the scroll direction.
module dm_scroll_feeder
   import dm_pkg::*;
#(
   parameter int COLS     = COLS_DEF,
   parameter int ROWS     = ROWS_DEF,
   parameter int ID_W     = 5,
   parameter int MSG_COLS = 64,
   parameter int TICK_DIV = 50000,
   localparam int AW = $clog2(MSG_COLS)
)(
   input  logic            CLK,
   input  logic            RESET,
   input  logic            EN,
`ifdef DM_FEEDER_DIR_EN
   input  logic            DIR,
`endif
   output logic [AW-1:0]   src_addr,
   input  logic [ROWS-1:0] src_data,
   output logic            LOAD,
   output logic [ID_W-1:0] column_id,
   output logic [ROWS-1:0] in_column,
   output logic            IN_CLR,
   output logic            busy,
   output logic            frame_done
);
   state_t state, nxt;
   logic [AW-1:0] offset, offset_n;
   logic [ID_W-1:0] col, col_n;
   logic pending, pending_n, tick, adv, last, dir;
`ifdef DM_FEEDER_DIR_EN
   assign dir = DIR;
`else
   assign dir = 1'b0;
`endif
   dm_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLK(CLK),
      .RESET(RESET),
      .run(state != IDLE),
      .tick(tick)
   );
   always_comb begin
      last = col == ID_W'(COLS - 1);
      adv = state == WAIT && EN && (tick || pending);
      nxt = state == IDLE  ? (EN ? CLEAR : IDLE)
          : state == CLEAR ? FETCH
          : state == FETCH ? WRITE
          : state == WRITE ? (last ? WAIT : FETCH)
          : !EN            ? IDLE
          : adv            ? FETCH
          :                  WAIT;
      offset_n = !adv ? offset
               : dir  ? AW'(wrap_sub(32'(offset), 1, MSG_COLS))
               :        AW'(wrap_add(32'(offset), 1, MSG_COLS));
      col_n = state == CLEAR ? '0 : state == WRITE ? (last ? '0 : col + 1'b1) : col;
      // a tick outside WAIT is remembered once; WAIT either consumes it or abandons it on stop
      pending_n = (state == IDLE || state == WAIT) ? 1'b0 : pending | tick;
   end
   always_ff @(posedge CLK)
      if (!RESET) begin
         state      <= IDLE;
         offset     <= '0;
         col        <= '0;
         pending    <= 1'b0;
         src_addr   <= '0;
         LOAD       <= 1'b0;
         column_id  <= '0;
         in_column  <= '0;
         IN_CLR     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt;
         offset     <= offset_n;
         col        <= col_n;
         pending    <= pending_n;
         IN_CLR     <= nxt == CLEAR;
         busy       <= nxt == FETCH || nxt == WRITE;
         if (nxt == FETCH) src_addr <= AW'(wrap_add(32'(offset_n), 32'(col_n), MSG_COLS));
         // source data arrives during WRITE, so the driver strobe lands one cycle later
         LOAD       <= state == WRITE;
         frame_done <= state == WRITE && last;
         if (state == WRITE) begin
            column_id <= col;
            in_column <= src_data;
         end
      end
endmodule

// File: tb/tb_dm_scroll_feeder.sv
// tb_dm_scroll_feeder: directed marquee scenarios checked against a frame-position model
module tb_dm_scroll_feeder;
   localparam int C = 16, M = 20, TD = 64;
   logic clk = 0, rst_n = 0, en = 1, dir = 0;
   logic [4:0] src_addr, column_id;
   logic [15:0] src_data = 0, in_column;
   logic LOAD, IN_CLR, busy, frame_done;
   int vecs = 0, errs = 0;
   bit ftick = 0;
   always #5 clk = ~clk;
   always @(posedge clk) src_data <= 16'hA000 | 16'(src_addr);
   dm_scroll_feeder #(.COLS(C), .ROWS(16), .ID_W(5), .MSG_COLS(M), .TICK_DIV(TD)) dut (
      .CLK(clk),
      .RESET(rst_n),
      .EN(en),
`ifdef DM_FEEDER_DIR_EN
      .DIR(dir),
`endif
      .src_addr(src_addr),
      .src_data(src_data),
      .LOAD(LOAD),
      .column_id(column_id),
      .in_column(in_column),
      .IN_CLR(IN_CLR),
      .busy(busy),
      .frame_done(frame_done)
   );
   function automatic void chk(input string nm, input int a, input int e);
      vecs++;
      if (a != e) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endfunction
   // model: ph = -2 idle, -1 clear, 0..2C-1 position within frame, 2C waiting for a step
   int ph = -2, cnt = 0, off = 0, e_id = 0, e_col = 0;
   bit pend = 0, e_load = 0, e_fd = 0, mrst = 0, t_m = 0;
   always @(posedge clk) begin
      if (!rst_n) begin
         ph = -2; cnt = 0; off = 0; pend = 0; e_load = 0; e_fd = 0; mrst = 1;
      end else begin
         mrst = 0;
         t_m = ftick || (ph != -2 && cnt == TD - 1);
         e_load = ph >= 0 && ph < 2 * C && ph % 2 == 1;
         e_fd = ph == 2 * C - 1;
         if (e_load) begin
            e_id = ph / 2;
            e_col = 'hA000 | ((off + ph / 2) % M);
         end
         cnt = (ph == -2 || cnt == TD - 1) ? 0 : cnt + 1;
         if (ph == -2) ph = en ? -1 : -2;
         else if (ph < 2 * C) begin
            pend = pend | t_m;
            ph++;
         end else if (!en) begin
            ph = -2; pend = 0;
         end else if (t_m || pend) begin
            off = dir ? (off + M - 1) % M : (off + 1) % M;
            pend = 0; ph = 0;
         end
      end
   end
   bit prev_load = 0;
   always @(negedge clk) begin
      chk("LOAD", int'(LOAD), int'(e_load));
      chk("IN_CLR", int'(IN_CLR), int'(ph == -1));
      chk("busy", int'(busy), int'(ph >= 0 && ph < 2 * C));
      chk("frame_done", int'(frame_done), int'(e_fd));
      chk("load_gap", int'(prev_load & LOAD), 0);
      prev_load = LOAD;
      if (e_load) begin
         chk("column_id", int'(column_id), e_id);
         chk("in_column", int'(in_column), e_col);
      end
      if (ph >= 0 && ph < 2 * C && ph % 2 == 0) chk("src_addr", int'(src_addr), (off + ph / 2) % M);
      if (mrst) begin
         chk("rst_column_id", int'(column_id), 0);
         chk("rst_in_column", int'(in_column), 0);
         chk("rst_src_addr", int'(src_addr), 0);
      end
   end
   logic [15:0] cap [C];
   always @(negedge clk) if (LOAD) cap[column_id] = in_column;
   task automatic wait_for(input int which, input string nm, output int n);
      bit hit;
      hit = 0; n = 0;
      while (!hit && n < 200) begin
         @(negedge clk);
         n++;
         hit = which == 0 ? IN_CLR : which == 1 ? busy : which == 2 ? frame_done : (LOAD && column_id == 5);
      end
      #1;
      vecs++;
      if (!hit) begin
         errs++;
         $display("FAIL wait_%s: got no event in %0d cycles, expected one", nm, n);
      end
   endtask
   task automatic grab(input string nm);
      int n;
      wait_for(2, nm, n);
   endtask
   task automatic pulse_tick();
      ftick = 1;
      force dut.tick = 1'b1;
      @(negedge clk);
      ftick = 0;
      release dut.tick;
   endtask
   initial begin
      int n, nl;
      repeat (5) @(negedge clk);
      rst_n = 1;
      wait_for(0, "clr", n);
      wait_for(1, "first_fetch", n);
      chk("clr_to_fetch", n, 1);
      wait_for(2, "first_done", n);
      chk("fetch_to_done", n, 32);
      for (int i = 0; i < C; i++) chk($sformatf("frame0_col%0d", i), int'(cap[i]), 'hA000 + i);
      for (int i = 0; i < 6; i++) grab("scroll");
      chk("off6_col0", int'(cap[0]), 'hA006);
      chk("off6_col14", int'(cap[14]), 'hA000);
      chk("off6_col15", int'(cap[15]), 'hA001);
      wait_for(1, "frame_a", n);
      repeat (10) @(negedge clk);
      pulse_tick();
      grab("frame_a_done");
      @(negedge clk);
      chk("pend_restart", int'(busy), 1);
      repeat (5) @(negedge clk);
      pulse_tick();
      repeat (6) @(negedge clk);
      pulse_tick();
      grab("frame_b_done");
      chk("frame_b_col0", int'(cap[0]), 'hA008);
      @(negedge clk);
      chk("pend_restart2", int'(busy), 1);
      grab("frame_c_done");
      chk("frame_c_col0", int'(cap[0]), 'hA009);
      chk("frame_c_col15", int'(cap[15]), 'hA004);
      @(negedge clk);
      chk("no_queue", int'(busy), 0);
      wait_for(3, "col5", n);
      en = 0;
      grab("en_drop_done");
      chk("drop_col6", int'(cap[6]), 'hA010);
      chk("drop_col15", int'(cap[15]), 'hA005);
      nl = 0;
      repeat (10) begin
         @(negedge clk);
         nl += int'(LOAD | busy);
      end
      chk("idle_quiet", nl, 0);
      en = 1;
      wait_for(0, "reclr", n);
      grab("resume_done");
      chk("resume_col0", int'(cap[0]), 'hA00A);
      chk("resume_col12", int'(cap[12]), 'hA002);
      wait_for(1, "pre_rst", n);
      repeat (7) @(negedge clk);
      rst_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      wait_for(0, "rst_clr", n);
      grab("post_rst_done");
      chk("post_rst_col0", int'(cap[0]), 'hA000);
      chk("post_rst_col5", int'(cap[5]), 'hA005);
`ifdef DM_FEEDER_DIR_EN
      rst_n = 0;
      dir = 1;
      repeat (3) @(negedge clk);
      rst_n = 1;
      grab("dir_first");
      chk("dir_off0_col0", int'(cap[0]), 'hA000);
      grab("dir_second");
      chk("dir_col0", int'(cap[0]), 'hA013);
      chk("dir_col1", int'(cap[1]), 'hA000);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
